// File: rtl/pmm_feeder_if.sv
// rtl/pmm_feeder_if.sv - upstream word stream and PMM handshake bundle for one feeder lane
interface pmm_feeder_if;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic [15:0] in_control;
  logic [63:0] pmm_data;
  logic [15:0] pmm_control;
  logic        pmm_data_valid;
  logic        pmm_ready_status;
  logic        pmm_accepted_status;

  modport master (
    input  in_valid, in_data, in_control, pmm_ready_status, pmm_accepted_status,
    output in_ready, pmm_data, pmm_control, pmm_data_valid
  );

  modport slave (
    output in_valid, in_data, in_control, pmm_ready_status, pmm_accepted_status,
    input  in_ready, pmm_data, pmm_control, pmm_data_valid
  );
endinterface

// File: rtl/pmm_feeder.sv
// rtl/pmm_feeder.sv - buffered four-phase word transmitter and match counter for one PMM lane
module pmm_feeder #(
  parameter int DEPTH       = 4,
  parameter int TIMEOUT_CYC = 1024,
  parameter int CNT_W       = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  pmm_feeder_if.master           bus,
  input  logic                   clr_status,
  output logic                   match_pulse,
  output logic [CNT_W-1:0]       match_count,
  output logic                   timeout,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic                   busy
);
  localparam int AW = $clog2(DEPTH);
  // Phase counter only needs to reach TIMEOUT_CYC; keep at least one bit when disabled.
  localparam int TW = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {IDLE, REQ, REL} state_t;

  logic [79:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   level;
  logic          full;
  logic          push;
  logic          pop;
  logic          load;
  logic          tmo_hit;
  logic          tmo_fire;
  logic          acc_q;
  logic          match_edge;
  logic [TW-1:0] phase_cnt;
  state_t        state;
  state_t        state_nxt;

  assign full         = (level == (AW+1)'(DEPTH));
  assign bus.in_ready = !full;
  assign push         = bus.in_valid && !full;
  assign fifo_level   = level;
  assign busy         = (state != IDLE) || (level != '0);
  assign tmo_hit      = (TIMEOUT_CYC != 0) && (phase_cnt == TW'(TIMEOUT_CYC));
  assign match_edge   = bus.pmm_accepted_status && !acc_q;

  // Next-state logic: load head on IDLE exit, pop on release or on a timed-out phase.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    load      = 1'b0;
    tmo_fire  = 1'b0;
    case (state)
      IDLE: begin
        if (level != '0) begin
          load      = 1'b1;
          state_nxt = REQ;
        end
      end
      REQ: begin
        if (bus.pmm_ready_status) begin
          state_nxt = REL;
        end else if (tmo_hit) begin
          tmo_fire  = 1'b1;
          pop       = 1'b1;
          state_nxt = IDLE;
        end
      end
      REL: begin
        if (!bus.pmm_ready_status) begin
          pop       = 1'b1;
          state_nxt = IDLE;
        end else if (tmo_hit) begin
          tmo_fire  = 1'b1;
          pop       = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Phase counter reads 1 in the first cycle of REQ/REL, so it equals cycles spent in the phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  phase_cnt <= '0;
    else if (state_nxt != state) phase_cnt <= TW'(1);
    else if (state != IDLE)      phase_cnt <= phase_cnt + TW'(1);
  end

  // FIFO storage; contents need no reset because level gates every read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {bus.in_control, bus.in_data};
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      level <= level + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  // PMM-facing outputs: valid tracks REQ, word only changes when a new head is loaded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.pmm_data_valid <= 1'b0;
      bus.pmm_data       <= '0;
      bus.pmm_control    <= '0;
    end else begin
      bus.pmm_data_valid <= (state_nxt == REQ);
      if (load) {bus.pmm_control, bus.pmm_data} <= mem[rd_ptr];
    end
  end

  // Accepted-status edge detect and saturating match count; clear beats a same-cycle edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q       <= 1'b0;
      match_pulse <= 1'b0;
      match_count <= '0;
    end else begin
      acc_q       <= bus.pmm_accepted_status;
      match_pulse <= match_edge;
      if (clr_status)                     match_count <= '0;
      else if (match_edge && !(&match_count)) match_count <= match_count + CNT_W'(1);
    end
  end

  // Sticky timeout flag; clear beats a same-cycle timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          timeout <= 1'b0;
    else if (clr_status) timeout <= 1'b0;
    else if (tmo_fire)   timeout <= 1'b1;
  end
endmodule

// File: tb/tb_pmm_feeder.sv
// tb/tb_pmm_feeder.sv - self-checking bench for pmm_feeder
module tb_pmm_feeder;
  localparam int DEPTH = 4;
  localparam int TMO   = 8;
  localparam int CW    = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clr_status = 1'b0;
  logic          match_pulse;
  logic [CW-1:0] match_count;
  logic          timeout;
  logic [2:0]    fifo_level;
  logic          busy;

  pmm_feeder_if bif();

  pmm_feeder #(.DEPTH(DEPTH), .TIMEOUT_CYC(TMO), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bif.master), .clr_status(clr_status),
    .match_pulse(match_pulse), .match_count(match_count), .timeout(timeout),
    .fifo_level(fifo_level), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       acc;
    logic       clr;
    logic       pulse;
    logic [1:0] count;
  } mvec_t;

  int          checks = 0;
  int          errors = 0;
  logic [79:0] src_q[$];
  logic [79:0] exp_q[$];
  logic [79:0] cur;
  logic [79:0] w;
  int          lvl, phase, dly, deliv;
  int          src_pct, lat_lo, lat_hi, rel_lo, rel_hi;
  bit          acc_rand, clr_rand;
  logic        acc_prev;
  int          cnt_m;
  logic        tmo_m;
  int          vcnt;
  mvec_t       tbl [13];

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chkw(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_word(input logic [79:0] v);
    bif.in_control = v[79:64];
    bif.in_data    = v[63:0];
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bif.in_valid = 1'b0;
    drive_word('0);
    bif.pmm_ready_status = 1'b0;
    bif.pmm_accepted_status = 1'b0;
    clr_status = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    src_q.delete();
    exp_q.delete();
    lvl = 0; phase = 0; dly = 0; deliv = 0;
    acc_prev = 1'b0; cnt_m = 0; tmo_m = 1'b0;
    acc_rand = 1'b0; clr_rand = 1'b0; src_pct = 0;
    lat_lo = 0; lat_hi = 0; rel_lo = 0; rel_hi = 0;
    tick();
  endtask

  // One clock of source + PMM responder + reference model + per-cycle checks.
  task automatic cycle();
    bit push_now, pop_now, edge_now;
    pop_now = 1'b0;
    if (!bif.in_valid && src_q.size() != 0 && $urandom_range(99) < src_pct) begin
      bif.in_valid = 1'b1;
      drive_word(src_q[0]);
    end
    if (phase == 0 && bif.pmm_data_valid) begin
      if (exp_q.size() == 0) chk1("spurious_valid", bif.pmm_data_valid, 1'b0);
      else begin
        cur = exp_q.pop_front();
        phase = 1;
        dly = $urandom_range(lat_hi, lat_lo);
      end
    end
    if (phase == 1) chk1("req_valid", bif.pmm_data_valid, 1'b1);
    if ((phase == 1 || phase == 2) && bif.pmm_data_valid)
      chkw("req_word", {bif.pmm_control, bif.pmm_data}, cur);
    if (phase == 1) begin
      if (dly == 0) begin bif.pmm_ready_status = 1'b1; phase = 2; end
      else dly--;
    end
    if (phase == 2 && !bif.pmm_data_valid) begin
      phase = 3;
      dly = $urandom_range(rel_hi, rel_lo);
    end
    if (phase == 3) begin
      if (dly == 0) begin
        bif.pmm_ready_status = 1'b0; pop_now = 1'b1; phase = 0; deliv++;
      end else dly--;
    end
    bif.pmm_accepted_status = acc_rand ? ($urandom_range(1) == 1) : 1'b0;
    clr_status = clr_rand ? ($urandom_range(15) == 0) : 1'b0;
    edge_now = bif.pmm_accepted_status && !acc_prev;
    push_now = bif.in_valid && bif.in_ready;
    tick();
    if (push_now) begin
      w = src_q.pop_front();
      exp_q.push_back(w);
      bif.in_valid = 1'b0;
    end
    lvl = lvl + int'(push_now) - int'(pop_now);
    acc_prev = bif.pmm_accepted_status;
    if (clr_status) begin cnt_m = 0; tmo_m = 1'b0; end
    else if (edge_now && cnt_m < (1 << CW) - 1) cnt_m++;
    chki("fifo_level", int'(fifo_level), lvl);
    chk1("in_ready", bif.in_ready, lvl < DEPTH);
    chk1("busy", busy, lvl != 0);
    chk1("match_pulse", match_pulse, edge_now);
    chki("match_count", int'(match_count), cnt_m);
    chk1("timeout", timeout, tmo_m);
  endtask

  task automatic drain(input int bound);
    for (int c = 0; c < bound; c++) begin
      if (src_q.size() == 0 && lvl == 0 && phase == 0 && !bif.in_valid) break;
      cycle();
    end
    bif.pmm_accepted_status = 1'b0;
    clr_status = 1'b0;
  endtask

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 1'b1, 2'd1};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 2'd1};
    tbl[2]  = '{1'b1, 1'b0, 1'b1, 2'd2};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 2'd2};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 2'd2};
    tbl[5]  = '{1'b1, 1'b0, 1'b1, 2'd3};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 2'd3};
    tbl[7]  = '{1'b1, 1'b0, 1'b1, 2'd3};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 2'd0};
    tbl[9]  = '{1'b1, 1'b0, 1'b1, 2'd1};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 2'd1};
    tbl[11] = '{1'b1, 1'b1, 1'b1, 2'd0};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 2'd0};

    // Reset values
    do_reset();
    chk1("rst_in_ready", bif.in_ready, 1'b1);
    chk1("rst_valid", bif.pmm_data_valid, 1'b0);
    chkw("rst_word", {bif.pmm_control, bif.pmm_data}, 80'h0);
    chk1("rst_pulse", match_pulse, 1'b0);
    chki("rst_count", int'(match_count), 0);
    chk1("rst_timeout", timeout, 1'b0);
    chki("rst_level", int'(fifo_level), 0);
    chk1("rst_busy", busy, 1'b0);

    // Match detection table, including saturation and clear-vs-edge
    for (int i = 0; i < 13; i++) begin
      bif.pmm_accepted_status = tbl[i].acc;
      clr_status = tbl[i].clr;
      tick();
      chk1($sformatf("tbl_pulse[%0d]", i), match_pulse, tbl[i].pulse);
      chki($sformatf("tbl_count[%0d]", i), int'(match_count), int'(tbl[i].count));
    end
    bif.pmm_accepted_status = 1'b0;
    clr_status = 1'b0;

    // Single word, ack two cycles after valid, release one cycle after valid falls
    do_reset();
    w = {16'h0001, 64'hDEADBEEF_00000001};
    bif.in_valid = 1'b1; drive_word(w);
    tick();
    bif.in_valid = 1'b0;
    chki("sw_level_push", int'(fifo_level), 1);
    chk1("sw_valid_early", bif.pmm_data_valid, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk1($sformatf("sw_valid[%0d]", i), bif.pmm_data_valid, 1'b1);
      chkw($sformatf("sw_word[%0d]", i), {bif.pmm_control, bif.pmm_data}, w);
    end
    bif.pmm_ready_status = 1'b1;
    tick();
    chk1("sw_valid_fall", bif.pmm_data_valid, 1'b0);
    chki("sw_level_rel", int'(fifo_level), 1);
    tick();
    bif.pmm_ready_status = 1'b0;
    chki("sw_level_hold", int'(fifo_level), 1);
    tick();
    chki("sw_level_pop", int'(fifo_level), 0);
    chk1("sw_busy", busy, 1'b0);

    // Back-pressure: five words into a four-deep FIFO with a slow PMM
    do_reset();
    src_pct = 100; lat_lo = 4; lat_hi = 4;
    for (int i = 1; i <= 5; i++) src_q.push_back({16'(16'h00F0 + i), 64'(64'h1000 + i)});
    repeat (4) cycle();
    chk1("bp_full_ready", bif.in_ready, 1'b0);
    chki("bp_full_level", int'(fifo_level), 4);
    cycle();
    chk1("bp_held", bif.in_valid, 1'b1);
    drain(400);
    chki("bp_delivered", deliv, 5);

    // Push and pop in the same cycle at level 2
    do_reset();
    bif.in_valid = 1'b1; drive_word({16'hA, 64'hA});
    tick();
    drive_word({16'hB, 64'hB});
    tick();
    bif.in_valid = 1'b0;
    chki("pp_level2", int'(fifo_level), 2);
    chk1("pp_valid", bif.pmm_data_valid, 1'b1);
    bif.pmm_ready_status = 1'b1;
    tick();
    chk1("pp_rel", bif.pmm_data_valid, 1'b0);
    bif.pmm_ready_status = 1'b0;
    bif.in_valid = 1'b1; drive_word({16'hC, 64'hC});
    chk1("pp_ready", bif.in_ready, 1'b1);
    tick();
    bif.in_valid = 1'b0;
    chki("pp_level_same", int'(fifo_level), 2);
    exp_q.push_back({16'hB, 64'hB});
    exp_q.push_back({16'hC, 64'hC});
    lvl = 2; lat_hi = 2; rel_hi = 1;
    drain(200);
    chki("pp_delivered", deliv, 2);

    // Timeout with a PMM that never acks, then a normal word, then clear
    do_reset();
    bif.in_valid = 1'b1; drive_word({16'h7, 64'h7777});
    tick();
    drive_word({16'h8, 64'h8888});
    tick();
    bif.in_valid = 1'b0;
    vcnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (!bif.pmm_data_valid) break;
      vcnt++;
      if ({bif.pmm_control, bif.pmm_data} !== {16'h7, 64'h7777})
        chkw("to_word_stable", {bif.pmm_control, bif.pmm_data}, {16'h7, 64'h7777});
      tick();
    end
    chki("to_valid_cycles", vcnt, TMO);
    chk1("to_flag", timeout, 1'b1);
    chki("to_discard_level", int'(fifo_level), 1);
    tick();
    chk1("to_next_valid", bif.pmm_data_valid, 1'b1);
    chkw("to_next_word", {bif.pmm_control, bif.pmm_data}, {16'h8, 64'h8888});
    bif.pmm_ready_status = 1'b1;
    tick();
    bif.pmm_ready_status = 1'b0;
    tick();
    chki("to_next_pop", int'(fifo_level), 0);
    chk1("to_sticky", timeout, 1'b1);
    clr_status = 1'b1;
    tick();
    clr_status = 1'b0;
    chk1("to_cleared", timeout, 1'b0);

    // Reset asserted mid-REQ with three words queued
    do_reset();
    bif.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_word({16'(i), 64'(i + 32'h50)});
      tick();
    end
    bif.in_valid = 1'b0;
    chk1("mr_valid_before", bif.pmm_data_valid, 1'b1);
    chki("mr_level_before", int'(fifo_level), 3);
    #3;
    rst_n = 1'b0;
    #1;
    chk1("mr_valid", bif.pmm_data_valid, 1'b0);
    chki("mr_level", int'(fifo_level), 0);
    chk1("mr_in_ready", bif.in_ready, 1'b1);
    chk1("mr_busy", busy, 1'b0);
    do_reset();
    repeat (12) cycle();
    chki("mr_no_transfer", deliv, 0);

    // Randomized traffic against the reference model
    do_reset();
    src_pct = 60; lat_lo = 0; lat_hi = 3; rel_lo = 0; rel_hi = 2;
    acc_rand = 1'b1; clr_rand = 1'b1;
    for (int i = 0; i < 60; i++) src_q.push_back({16'($urandom), $urandom, $urandom});
    drain(3000);
    chki("rnd_delivered", deliv, 60);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end
endmodule
